// File: rtl/gbt_counter_checker.sv
// Receive-side checker for the GBT motor_data_b64 payload: locks to an incrementing
// 32-bit counter duplicated in both halves and reports lock, errors and statistics.
package ckrs_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

module gbt_counter_checker
    import ckrs_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 8,
    parameter int unsigned UNLOCK_COUNT = 4
) (
    input  ckrs_t        ClkRs_ix,
    input  logic [63:0]  data_ib64,
    input  logic         dvalid_i,
    input  logic         rx_ready_i,
    input  logic         clear_i,
    output logic         locked_o,
    output logic         error_o,
    output logic [31:0]  err_cnt_ob32,
    output logic [31:0]  word_cnt_ob32,
    output logic [63:0]  last_bad_ob64
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_CNT_C = 8'(UNLOCK_COUNT);

    logic [1:0]  state_q, state_d;
    logic [31:0] expected_q, expected_d;
    logic [7:0]  good_run_q, good_run_d;
    logic [7:0]  bad_run_q, bad_run_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [63:0] last_bad_q, last_bad_d;
    logic        error_q, error_d;

    logic [31:0] lo_w, hi_w;
    logic        halves_eq_w, word_good_w;
    logic [7:0]  good_inc_w, bad_inc_w;

    assign lo_w        = data_ib64[31:0];
    assign hi_w        = data_ib64[63:32];
    assign halves_eq_w = (hi_w == lo_w);
    assign word_good_w = halves_eq_w && (lo_w == expected_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        expected_d = expected_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        last_bad_d = last_bad_q;
        error_d    = 1'b0;
        good_inc_w = 8'd0;
        bad_inc_w  = 8'd0;

        if (!rx_ready_i) begin
            state_d    = IDLE;
            good_run_d = 8'd0;
            bad_run_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ACQUIRE;
                    good_run_d = 8'd0;
                    bad_run_d  = 8'd0;
                end
                ACQUIRE: if (dvalid_i) begin
                    if (!halves_eq_w) begin
                        good_run_d = 8'd0;
                    end else begin
                        // A mismatch with a run in progress reseeds on this word rather than discarding it.
                        good_inc_w = (good_run_q == 8'd0 || lo_w == expected_q) ? good_run_q + 8'd1 : 8'd1;
                        good_run_d = good_inc_w;
                        expected_d = lo_w + 32'd1;
                        if (good_inc_w == LOCK_CNT_C) begin
                            state_d    = LOCKED;
                            good_run_d = 8'd0;
                            bad_run_d  = 8'd0;
                        end
                    end
                end
                LOCKED: if (dvalid_i) begin
                    expected_d = expected_q + 32'd1;
                    word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 32'd1;
                    if (word_good_w) begin
                        bad_run_d = 8'd0;
                    end else begin
                        bad_inc_w  = bad_run_q + 8'd1;
                        bad_run_d  = bad_inc_w;
                        err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 32'd1;
                        last_bad_d = data_ib64;
                        error_d    = 1'b1;
                        if (bad_inc_w == UNLOCK_CNT_C) begin
                            state_d    = ACQUIRE;
                            good_run_d = 8'd0;
                            bad_run_d  = 8'd0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (clear_i) begin
            err_cnt_d  = 32'd0;
            word_cnt_d = 32'd0;
            last_bad_d = 64'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            state_q    <= IDLE;
            expected_q <= 32'd0;
            good_run_q <= 8'd0;
            bad_run_q  <= 8'd0;
            err_cnt_q  <= 32'd0;
            word_cnt_q <= 32'd0;
            last_bad_q <= 64'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
            last_bad_q <= last_bad_d;
            error_q    <= error_d;
        end
    end

    assign locked_o      = (state_q == LOCKED);
    assign error_o       = error_q;
    assign err_cnt_ob32  = err_cnt_q;
    assign word_cnt_ob32 = word_cnt_q;
    assign last_bad_ob64 = last_bad_q;

endmodule

// File: tb/tb_gbt_counter_checker.sv
// Directed bench for gbt_counter_checker: lock, corruption, dropped word, clear collision,
// receiver loss and counter wrap, with hand-computed expectations.
module tb_gbt_counter_checker;
    import ckrs_pkg::*;

    ckrs_t       ClkRs;
    logic [63:0] data;
    logic        dvalid;
    logic        rx_ready;
    logic        clear;
    logic        locked;
    logic        error;
    logic [31:0] err_cnt;
    logic [31:0] word_cnt;
    logic [63:0] last_bad;

    int vectors     = 0;
    int miscompares = 0;

    gbt_counter_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(4)) dut (
        .ClkRs_ix      (ClkRs),
        .data_ib64     (data),
        .dvalid_i      (dvalid),
        .rx_ready_i    (rx_ready),
        .clear_i       (clear),
        .locked_o      (locked),
        .error_o       (error),
        .err_cnt_ob32  (err_cnt),
        .word_cnt_ob32 (word_cnt),
        .last_bad_ob64 (last_bad)
    );

    always #5 ClkRs.clk = ~ClkRs.clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Two idle frame slots, then one word with dvalid; returns at the falling edge after the sampling edge.
    task automatic send(input logic [63:0] w, input logic clr);
        repeat (2) @(negedge ClkRs.clk);
        data   = w;
        dvalid = 1'b1;
        clear  = clr;
        @(negedge ClkRs.clk);
        dvalid = 1'b0;
        clear  = 1'b0;
    endtask

    function automatic logic [63:0] dup(input logic [31:0] n);
        return {n, n};
    endfunction

    initial begin
        ClkRs.clk   = 1'b0;
        ClkRs.reset = 1'b1;
        data        = 64'd0;
        dvalid      = 1'b0;
        rx_ready    = 1'b0;
        clear       = 1'b0;
        repeat (3) @(negedge ClkRs.clk);
        chk("reset_locked",   {63'd0, locked}, 64'd0);
        chk("reset_error",    {63'd0, error},  64'd0);
        chk("reset_err_cnt",  {32'd0, err_cnt},  64'd0);
        chk("reset_word_cnt", {32'd0, word_cnt}, 64'd0);
        chk("reset_last_bad", last_bad, 64'd0);

        ClkRs.reset = 1'b0;
        rx_ready    = 1'b1;

        // Acquire: locks on the 8th consecutive word (107)
        for (int n = 100; n <= 106; n++) send(dup(32'(n)), 1'b0);
        chk("acq_not_locked_106", {63'd0, locked}, 64'd0);
        send(dup(32'd107), 1'b0);
        chk("locked_after_107", {63'd0, locked}, 64'd1);
        chk("acq_word_cnt", {32'd0, word_cnt}, 64'd0);

        for (int n = 108; n <= 149; n++) send(dup(32'(n)), 1'b0);
        chk("word_cnt_149", {32'd0, word_cnt}, 64'd42);
        chk("err_cnt_149",  {32'd0, err_cnt},  64'd0);

        // Single corruption at 150
        send({32'd150, 32'd151}, 1'b0);
        chk("corrupt_error_pulse", {63'd0, error}, 64'd1);
        chk("corrupt_err_cnt",  {32'd0, err_cnt}, 64'd1);
        chk("corrupt_last_bad", last_bad, 64'h0000_0096_0000_0097);
        chk("corrupt_locked",   {63'd0, locked}, 64'd1);
        @(negedge ClkRs.clk);
        chk("corrupt_error_one_cycle", {63'd0, error}, 64'd0);
        send(dup(32'd151), 1'b0);
        chk("after_corrupt_good", {63'd0, error}, 64'd0);
        for (int n = 152; n <= 159; n++) send(dup(32'(n)), 1'b0);
        chk("word_cnt_159", {32'd0, word_cnt}, 64'd52);
        chk("err_cnt_159",  {32'd0, err_cnt},  64'd1);

        // Dropped word 160: 161..164 all miscompare, unlock after the 4th
        for (int n = 161; n <= 163; n++) begin
            send(dup(32'(n)), 1'b0);
            chk("drop_error", {63'd0, error}, 64'd1);
            chk("drop_still_locked", {63'd0, locked}, 64'd1);
        end
        send(dup(32'd164), 1'b0);
        chk("drop_unlocked", {63'd0, locked}, 64'd0);
        chk("drop_err_cnt",  {32'd0, err_cnt}, 64'd5);
        chk("drop_word_cnt", {32'd0, word_cnt}, 64'd56);
        chk("drop_last_bad", last_bad, dup(32'd164));

        for (int n = 165; n <= 171; n++) send(dup(32'(n)), 1'b0);
        chk("reacq_not_locked", {63'd0, locked}, 64'd0);
        send(dup(32'd172), 1'b0);
        chk("relocked_172", {63'd0, locked}, 64'd1);
        for (int n = 173; n <= 199; n++) send(dup(32'(n)), 1'b0);
        chk("word_cnt_199", {32'd0, word_cnt}, 64'd83);
        chk("err_cnt_199",  {32'd0, err_cnt},  64'd5);

        // Clear collides with a bad word (expected 200)
        send(64'h1234_5678_9ABC_DEF0, 1'b1);
        chk("clear_err_cnt",  {32'd0, err_cnt},  64'd0);
        chk("clear_word_cnt", {32'd0, word_cnt}, 64'd0);
        chk("clear_last_bad", last_bad, 64'd0);
        chk("clear_error",    {63'd0, error}, 64'd1);
        chk("clear_locked",   {63'd0, locked}, 64'd1);
        send(dup(32'd201), 1'b0);
        chk("post_clear_word_cnt", {32'd0, word_cnt}, 64'd1);
        chk("post_clear_error",    {63'd0, error}, 64'd0);

        // Receiver loss with a word in the same cycle: word ignored, stats retained
        repeat (2) @(negedge ClkRs.clk);
        rx_ready = 1'b0;
        data     = dup(32'd202);
        dvalid   = 1'b1;
        @(negedge ClkRs.clk);
        dvalid = 1'b0;
        chk("rxloss_locked",   {63'd0, locked}, 64'd0);
        chk("rxloss_word_cnt", {32'd0, word_cnt}, 64'd1);
        chk("rxloss_error",    {63'd0, error}, 64'd0);
        repeat (3) @(negedge ClkRs.clk);
        chk("idle_err_cnt", {32'd0, err_cnt}, 64'd0);
        rx_ready = 1'b1;

        // Resume across the 32-bit wrap: lock on 0xFFFFFFFF, 16 counted words after
        for (int k = 0; k < 7; k++) send(dup(32'hFFFF_FFF8 + 32'(k)), 1'b0);
        chk("wrap_not_locked", {63'd0, locked}, 64'd0);
        send(dup(32'hFFFF_FFFF), 1'b0);
        chk("wrap_locked", {63'd0, locked}, 64'd1);
        for (int k = 0; k < 16; k++) send(dup(32'(k)), 1'b0);
        chk("wrap_locked_end", {63'd0, locked}, 64'd1);
        chk("wrap_err_cnt",  {32'd0, err_cnt},  64'd0);
        chk("wrap_word_cnt", {32'd0, word_cnt}, 64'd17);

        // Final reset clears everything
        @(negedge ClkRs.clk);
        ClkRs.reset = 1'b1;
        @(negedge ClkRs.clk);
        ClkRs.reset = 1'b0;
        chk("final_reset_locked",   {63'd0, locked}, 64'd0);
        chk("final_reset_word_cnt", {32'd0, word_cnt}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
